// File: rtl/cfg_bank_spi.sv
// Serial configuration bank: deserialises address/data/parity frames and commits
// them atomically to N_REGS trim registers, with error status and a daisy-chain output.
module cfg_bank_spi #(
  parameter int DATA_W    = 14,
  parameter int ADDR_W    = 2,
  parameter int N_REGS    = 3,
  parameter int PARITY_EN = 1
) (
  input  logic                     Clk,
  input  logic                     Resetn,
  input  logic                     Cfg_en,
  input  logic                     Cfg_in,
  output logic [N_REGS*DATA_W-1:0] Cfg_out,
  output logic [N_REGS-1:0]        Upd,
  output logic [1:0]               Err,
  output logic                     Sdo
);

  localparam int FRAME_LEN = ADDR_W + DATA_W + PARITY_EN;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_PAR  = 2'd2;
  localparam logic [1:0] ERR_ADDR = 2'd3;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] sr_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 shift_en;
  logic                 frame_end;
  logic                 commit;
  logic [1:0]           err_d;
  logic [ADDR_W-1:0]    frame_addr;
  logic [DATA_W-1:0]    frame_data;

  // An even number of ones across the whole frame means the odd-parity bit is wrong.
  function automatic logic parity_bad(input logic [FRAME_LEN-1:0] f);
    return (PARITY_EN != 0) && !(^f);
  endfunction

  assign frame_addr = sr_q[FRAME_LEN-1 -: ADDR_W];
  assign frame_data = sr_q[DATA_W+PARITY_EN-1 : PARITY_EN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_en  = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (Cfg_en) begin
          shift_en = 1'b1;
          cnt_d    = CNT_ONE;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (Cfg_en) begin
          shift_en = 1'b1;
          cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end else begin
          frame_end = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame qualification, highest-priority error wins.
  always_comb begin
    err_d  = ERR_OK;
    commit = 1'b0;
    if (cnt_q != CNT_FULL) begin
      err_d = ERR_LEN;
    end else if (parity_bad(sr_q)) begin
      err_d = ERR_PAR;
    end else if (int'(frame_addr) >= N_REGS) begin
      err_d = ERR_ADDR;
    end else begin
      commit = frame_end;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      Sdo     <= 1'b0;
      Err     <= ERR_OK;
      Upd     <= '0;
      Cfg_out <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      Upd     <= '0;
      if (shift_en) begin
        sr_q <= {sr_q[FRAME_LEN-2:0], Cfg_in};
        Sdo  <= sr_q[FRAME_LEN-1];
      end
      if (frame_end) begin
        Err <= err_d;
        if (commit) begin
          for (int r = 0; r < N_REGS; r++) begin
            if (frame_addr == ADDR_W'(r)) begin
              Cfg_out[r*DATA_W +: DATA_W] <= frame_data;
              Upd[r]                      <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cfg_bank_spi.sv
// Bench for cfg_bank_spi: frame-level reference model checked every cycle, plus
// directed frames with literal expectations and a randomized frame stream.
module tb_cfg_bank_spi;

  localparam int DATA_W    = 14;
  localparam int ADDR_W    = 2;
  localparam int N_REGS    = 3;
  localparam int PARITY_EN = 1;
  localparam int FL        = ADDR_W + DATA_W + PARITY_EN;

  logic                     Clk    = 1'b0;
  logic                     Resetn = 1'b0;
  logic                     Cfg_en = 1'b0;
  logic                     Cfg_in = 1'b0;
  logic [N_REGS*DATA_W-1:0] Cfg_out;
  logic [N_REGS-1:0]        Upd;
  logic [1:0]               Err;
  logic                     Sdo;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  always #5 Clk = ~Clk;

  cfg_bank_spi #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REGS(N_REGS), .PARITY_EN(PARITY_EN)
  ) dut (
    .Clk(Clk), .Resetn(Resetn), .Cfg_en(Cfg_en), .Cfg_in(Cfg_in),
    .Cfg_out(Cfg_out), .Upd(Upd), .Err(Err), .Sdo(Sdo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is the list of bits seen while Cfg_en is high;
  // it is judged as a whole when Cfg_en drops. Sdo replays the qualified bit history.
  logic [DATA_W-1:0] m_regs [N_REGS];
  logic [N_REGS-1:0] m_upd = '0;
  logic [1:0]        m_err = '0;
  logic              m_sdo = 1'b0;
  bit                m_in_frame = 1'b0;
  bit                m_frame [$];
  bit                m_hist  [$];

  function automatic void model_reset();
    for (int r = 0; r < N_REGS; r++) m_regs[r] = '0;
    m_upd = '0;
    m_err = 2'd0;
    m_sdo = 1'b0;
    m_in_frame = 1'b0;
    m_frame.delete();
    m_hist.delete();
  endfunction

  function automatic void model_eval();
    int                ones = 0;
    int                a    = 0;
    logic [DATA_W-1:0] d    = '0;
    if (m_frame.size() != FL) begin
      m_err = 2'd1;
      return;
    end
    foreach (m_frame[i]) ones += int'(m_frame[i]);
    if (PARITY_EN != 0 && (ones % 2) == 0) begin
      m_err = 2'd2;
      return;
    end
    for (int i = 0; i < ADDR_W; i++) a = a * 2 + int'(m_frame[i]);
    for (int i = 0; i < DATA_W; i++) d = {d[DATA_W-2:0], m_frame[ADDR_W+i]};
    if (a >= N_REGS) begin
      m_err = 2'd3;
      return;
    end
    m_regs[a] = d;
    m_upd[a]  = 1'b1;
    m_err     = 2'd0;
  endfunction

  function automatic logic [N_REGS*DATA_W-1:0] m_out();
    logic [N_REGS*DATA_W-1:0] o;
    for (int r = 0; r < N_REGS; r++) o[r*DATA_W +: DATA_W] = m_regs[r];
    return o;
  endfunction

  always @(posedge Clk) begin : compare
    bit   en_s;
    bit   in_s;
    logic rst_s;
    en_s  = Cfg_en;
    in_s  = Cfg_in;
    rst_s = Resetn;
    #1;
    if (!rst_s || !Resetn) begin
      model_reset();
    end else begin
      m_upd = '0;
      if (en_s) begin
        if (!m_in_frame) begin
          m_in_frame = 1'b1;
          m_frame.delete();
        end
        m_frame.push_back(in_s);
        m_hist.push_back(in_s);
        if (m_hist.size() > FL) m_sdo = m_hist.pop_front();
      end else if (m_in_frame) begin
        m_in_frame = 1'b0;
        model_eval();
      end
    end
    chk("cfg_out", 64'(Cfg_out), 64'(m_out()));
    chk("upd", 64'(Upd), 64'(m_upd));
    chk("err", 64'(Err), 64'(m_err));
    chk("sdo", 64'(Sdo), 64'(m_sdo));
  end

  logic [31:0] sdo_cap = '0;

  task automatic cyc(input logic en, input logic b);
    @(negedge Clk);
    Cfg_en = en;
    Cfg_in = b;
    @(posedge Clk);
    #2;
    cyc_n++;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(1'b1, v[i]);
      sdo_cap = {sdo_cap[30:0], Sdo};
    end
  endtask

  task automatic end_frame();
    cyc(1'b0, 1'b0);
  endtask

  function automatic logic [FL-1:0] mk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                       input bit bad);
    logic p;
    p = ~^{a, d};
    return {a, d, p ^ logic'(bad)};
  endfunction

  initial begin : stim
    logic [FL-1:0] f1, f2;
    int            t1, t2;

    Resetn = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("rst_cfg_out", 64'(Cfg_out), 64'd0);
    chk("rst_upd", 64'(Upd), 64'd0);
    chk("rst_err", 64'(Err), 64'd0);
    chk("rst_sdo", 64'(Sdo), 64'd0);
    @(negedge Clk);
    Resetn = 1'b1;

    // Valid write to register 1
    send_bits(32'(mk(2'd1, 14'h2A5C, 1'b0)), FL);
    end_frame();
    chk("w1_reg1", 64'(Cfg_out[27:14]), 64'h2A5C);
    chk("w1_upd", 64'(Upd), 64'b010);
    chk("w1_err", 64'(Err), 64'd0);
    chk("w1_others", 64'({Cfg_out[41:28], Cfg_out[13:0]}), 64'd0);
    cyc(1'b0, 1'b0);
    chk("w1_upd_clear", 64'(Upd), 64'd0);

    // Parity error, then a good frame whose parity bit is 0
    send_bits(32'(mk(2'd1, 14'h2A5C, 1'b1)), FL);
    end_frame();
    chk("par_err", 64'(Err), 64'd2);
    chk("par_upd", 64'(Upd), 64'd0);
    chk("par_cfg", 64'(Cfg_out), 64'({14'h0, 14'h2A5C, 14'h0}));
    send_bits(32'(mk(2'd0, 14'h0001, 1'b0)), FL);
    end_frame();
    chk("w0_reg0", 64'(Cfg_out[13:0]), 64'h1);
    chk("w0_err", 64'(Err), 64'd0);
    chk("w0_upd", 64'(Upd), 64'b001);

    // Short and long frames
    send_bits($urandom, 16);
    end_frame();
    chk("len16_err", 64'(Err), 64'd1);
    chk("len16_cfg", 64'(Cfg_out), 64'({14'h0, 14'h2A5C, 14'h0001}));
    send_bits($urandom, 20);
    end_frame();
    chk("len20_err", 64'(Err), 64'd1);
    chk("len20_cfg", 64'(Cfg_out), 64'({14'h0, 14'h2A5C, 14'h0001}));

    // Address beyond the bank
    send_bits(32'(mk(2'd3, 14'h1234, 1'b0)), FL);
    end_frame();
    chk("addr_err", 64'(Err), 64'd3);
    chk("addr_upd", 64'(Upd), 64'd0);
    chk("addr_cfg", 64'(Cfg_out), 64'({14'h0, 14'h2A5C, 14'h0001}));

    // Back-to-back frames; Sdo replays frame 1 while frame 2 shifts in
    f1 = mk(2'd2, 14'h1357, 1'b0);
    f2 = mk(2'd0, 14'h2468, 1'b0);
    send_bits(32'(f1), FL);
    end_frame();
    t1 = cyc_n;
    chk("b2b_upd1", 64'(Upd), 64'b100);
    send_bits(32'(f2), FL);
    chk("sdo_chain", 64'(sdo_cap[FL-1:0]), 64'(f1));
    end_frame();
    t2 = cyc_n;
    chk("b2b_upd2", 64'(Upd), 64'b001);
    chk("b2b_spacing", 64'(t2 - t1), 64'd18);
    chk("b2b_cfg", 64'(Cfg_out), 64'({14'h1357, 14'h2A5C, 14'h2468}));

    // Reset in the middle of a frame aimed at a register holding 3FFF
    send_bits(32'(mk(2'd2, 14'h3FFF, 1'b0)), FL);
    end_frame();
    chk("pre_rst_reg2", 64'(Cfg_out[41:28]), 64'h3FFF);
    send_bits(32'(mk(2'd2, 14'h0055, 1'b0)) >> 8, 9);
    #1;
    Resetn = 1'b0;
    #1;
    chk("mid_rst_cfg", 64'(Cfg_out), 64'd0);
    chk("mid_rst_upd", 64'(Upd), 64'd0);
    chk("mid_rst_err", 64'(Err), 64'd0);
    chk("mid_rst_sdo", 64'(Sdo), 64'd0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    @(negedge Clk);
    Resetn = 1'b1;
    send_bits(32'(mk(2'd2, 14'h0ABC, 1'b0)), FL);
    end_frame();
    chk("post_rst_cfg", 64'(Cfg_out), 64'({14'h0ABC, 14'h0, 14'h0}));
    chk("post_rst_upd", 64'(Upd), 64'b100);

    // Randomized frame stream against the model
    repeat (250) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        send_bits(32'(mk(ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom),
                         ($urandom_range(0, 7) == 0))), FL);
      end else if (r < 9) begin
        send_bits($urandom, int'($urandom_range(1, 24)));
      end
      end_frame();
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom));
    end
    cyc(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
